register_file_multiport: RTL and testbench

Parametrised general-purpose register file for the next CPU generation. It provides configurable data width, register count and number of read ports, with register 0 hardwired to zero. Writes are fully synchronous on a single clock edge through a one-entry write stage, with optional read-after-write forwarding. After reset, a sequential clear engine zeroes every register, so no register starts undefined.

---
 rtl/register_file_multiport.sv | 110 +++++++++++
 tb/tb_register_file_multiport.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_multiport.sv
// rtl/register_file_multiport.sv - multiport register file with r0 hardwired to zero and a post-reset clear engine
// Optional feature macro: REGFILE_FORWARDING_EN (read-after-write bypass from the write stage)
module register_file_multiport #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int RD_PORTS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              d,
    input  logic                          n_load,
    input  logic [$clog2(DEPTH)-1:0]      d_sel,
    input  logic [RD_PORTS*$clog2(DEPTH)-1:0] rd_sel,
    input  logic [RD_PORTS-1:0]           rd_en,
    output logic [RD_PORTS*WIDTH-1:0]     rd_data,
    output logic                          busy
);

    localparam int SEL_W = $clog2(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   clr_idx;
    logic               clr_we;

    logic               ws_v;
    logic [SEL_W-1:0]   ws_sel;
    logic [WIDTH-1:0]   ws_d;

    // r0 has no storage; it is synthesised as a constant zero in the read mux
    logic [WIDTH-1:0]   regs [1:DEPTH-1];

    // FSM state register; reset always restarts the clear sequence
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Clear index walks r1..r(DEPTH-1), one register per edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_idx <= SEL_W'(1);
        end else if (state == ST_CLEAR) begin
            clr_idx <= clr_idx + SEL_W'(1);
        end
    end

    // Next state: leave CLEAR on the edge that clears the last register
    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_idx == SEL_W'(DEPTH - 1)) begin
            state_nxt = ST_RUN;
        end
    end

    // FSM outputs: busy and clear write strobe both follow the CLEAR state
    always_comb begin
        busy   = (state == ST_CLEAR);
        clr_we = (state == ST_CLEAR);
    end

    // Write stage capture; r0 writes and writes during CLEAR never become valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_v   <= 1'b0;
            ws_sel <= '0;
            ws_d   <= '0;
        end else if (state == ST_RUN) begin
            ws_v   <= !n_load && (d_sel != '0);
            ws_sel <= d_sel;
            ws_d   <= d;
        end else begin
            ws_v   <= 1'b0;
        end
    end

    // Storage update: clear engine has priority, otherwise commit the write stage
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs[clr_idx] <= '0;
        end else if (ws_v) begin
            regs[ws_sel] <= ws_d;
        end
    end

    // Combinational read mux; disabled ports, r0 and the CLEAR phase all read zero
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            if (!busy && rd_en[k] && rd_sel[k*SEL_W +: SEL_W] != '0) begin
                rd_data[k*WIDTH +: WIDTH] = regs[rd_sel[k*SEL_W +: SEL_W]];
`ifdef REGFILE_FORWARDING_EN
                if (ws_v && rd_sel[k*SEL_W +: SEL_W] == ws_sel) begin
                    rd_data[k*WIDTH +: WIDTH] = ws_d;
                end
`else
`endif
            end
        end
    end

endmodule

// File: tb/tb_register_file_multiport.sv
// tb/tb_register_file_multiport.sv - self-checking bench for register_file_multiport
module tb_register_file_multiport;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 16;
    localparam int RD_PORTS = 2;
    localparam int SEL_W    = $clog2(DEPTH);

    logic                      clk = 1'b0;
    logic                      reset;
    logic [WIDTH-1:0]          d;
    logic                      n_load;
    logic [SEL_W-1:0]          d_sel;
    logic [RD_PORTS*SEL_W-1:0] rd_sel;
    logic [RD_PORTS-1:0]       rd_en;
    logic [RD_PORTS*WIDTH-1:0] rd_data;
    logic                      busy;

    int tests = 0;
    int fails = 0;

    // Reference model: committed contents plus one pending write
    logic [WIDTH-1:0] mreg [DEPTH];
    logic             mv;
    logic [SEL_W-1:0] msel;
    logic [WIDTH-1:0] md;

`ifdef REGFILE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    register_file_multiport #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .RD_PORTS(RD_PORTS)
    ) dut (
        .clk(clk), .reset(reset), .d(d), .n_load(n_load), .d_sel(d_sel),
        .rd_sel(rd_sel), .rd_en(rd_en), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] exp_read(input logic [SEL_W-1:0] s, input logic e);
        if (!e || s == '0) return '0;
        if (FWD && mv && s == msel) return md;
        return mreg[s];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mreg[i] = '0;
        mv = 1'b0;
        msel = '0;
        md = '0;
    endtask

    // One clock with the given write request; returns at the following negedge
    task automatic write_cycle(input logic nl, input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] v);
        n_load = nl;
        d_sel  = s;
        d      = v;
        @(posedge clk);
        if (mv) mreg[msel] = md;
        mv   = !nl && (s != '0);
        msel = s;
        md   = v;
        @(negedge clk);
        n_load = 1'b1;
    endtask

    task automatic set_port(input int k, input logic [SEL_W-1:0] s, input logic e);
        rd_sel[k*SEL_W +: SEL_W] = s;
        rd_en[k] = e;
    endtask

    task automatic check_ports(input string name);
        logic [WIDTH-1:0] got;
        logic [WIDTH-1:0] exp;
        #1;
        for (int k = 0; k < RD_PORTS; k++) begin
            got = rd_data[k*WIDTH +: WIDTH];
            exp = exp_read(rd_sel[k*SEL_W +: SEL_W], rd_en[k]);
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL %s port%0d sel=%0d en=%0b: got %h expected %h",
                         name, k, rd_sel[k*SEL_W +: SEL_W], rd_en[k], got, exp);
            end
        end
    endtask

    // Waits for busy to drop after reset release, counting edges, with writes attempted throughout
    task automatic run_clear(input string name);
        int edges;
        edges = 0;
        n_load = 1'b0;
        d_sel  = SEL_W'(5);
        d      = 16'hDEAD;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if (busy === 1'b0) begin
                edges = i;
                break;
            end
            tests++;
            if (rd_data !== '0) begin
                fails++;
                $display("FAIL %s rd_data while busy: got %h expected 0", name, rd_data);
            end
        end
        n_load = 1'b1;
        tests++;
        if (edges != DEPTH - 1) begin
            fails++;
            $display("FAIL %s clear length: got %0d edges expected %0d", name, edges, DEPTH - 1);
        end
    endtask

    task automatic test_reset();
        n_load = 1'b1; d_sel = '0; d = '0;
        set_port(0, SEL_W'(5), 1'b1);
        set_port(1, SEL_W'(9), 1'b1);
        reset = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b1 || rd_data !== '0) begin
            fails++;
            $display("FAIL reset_state: busy=%b rd_data=%h expected busy=1 rd_data=0", busy, rd_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run_clear("clear");
        for (int r = 0; r < DEPTH; r++) begin
            set_port(0, SEL_W'(r), 1'b1);
            set_port(1, SEL_W'(r), 1'b1);
            check_ports("clear_zero");
        end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] want;
        set_port(0, SEL_W'(5), 1'b1);
        set_port(1, SEL_W'(0), 1'b0);
        write_cycle(1'b0, SEL_W'(5), 16'hBEEF);
        #1;
        want = FWD ? 16'hBEEF : 16'h0000;
        tests++;
        if (rd_data[WIDTH-1:0] !== want) begin
            fails++;
            $display("FAIL basic_after_N: got %h expected %h", rd_data[WIDTH-1:0], want);
        end
        check_ports("basic_after_N");
        write_cycle(1'b1, '0, '0);
        #1;
        tests++;
        if (rd_data[WIDTH-1:0] !== 16'hBEEF) begin
            fails++;
            $display("FAIL basic_after_N1: got %h expected beef", rd_data[WIDTH-1:0]);
        end
    endtask

    task automatic test_r0();
        set_port(0, '0, 1'b1);
        set_port(1, '0, 1'b1);
        write_cycle(1'b0, '0, 16'hFFFF);
        #1;
        tests++;
        if (rd_data !== '0 || dut.ws_v !== 1'b0) begin
            fails++;
            $display("FAIL r0_protect: rd_data=%h ws_v=%b expected 0 and 0", rd_data, dut.ws_v);
        end
        write_cycle(1'b1, '0, '0);
        check_ports("r0_after");
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] want;
        set_port(0, SEL_W'(3), 1'b1);
        set_port(1, SEL_W'(3), 1'b1);
        write_cycle(1'b0, SEL_W'(3), 16'h1111);
        write_cycle(1'b0, SEL_W'(3), 16'h2222);
        #1;
        want = FWD ? 16'h2222 : 16'h1111;
        tests++;
        if (rd_data[WIDTH-1:0] !== want || rd_data[2*WIDTH-1:WIDTH] !== want) begin
            fails++;
            $display("FAIL b2b_after_N1: got %h expected %h on both ports", rd_data, want);
        end
        write_cycle(1'b1, '0, '0);
        #1;
        tests++;
        if (rd_data[WIDTH-1:0] !== 16'h2222) begin
            fails++;
            $display("FAIL b2b_after_N2: got %h expected 2222", rd_data[WIDTH-1:0]);
        end
    endtask

    task automatic test_ports();
        write_cycle(1'b0, SEL_W'(1), 16'hA5A5);
        write_cycle(1'b0, SEL_W'(2), 16'h5A5A);
        write_cycle(1'b1, '0, '0);
        set_port(0, SEL_W'(1), 1'b1);
        set_port(1, SEL_W'(2), 1'b0);
        #1;
        tests++;
        if (rd_data[WIDTH-1:0] !== 16'hA5A5 || rd_data[2*WIDTH-1:WIDTH] !== 16'h0000) begin
            fails++;
            $display("FAIL ports_disabled: got %h expected 0000a5a5", rd_data);
        end
        set_port(1, SEL_W'(2), 1'b1);
        #1;
        tests++;
        if (rd_data[2*WIDTH-1:WIDTH] !== 16'h5A5A) begin
            fails++;
            $display("FAIL ports_enable: got %h expected 5a5a", rd_data[2*WIDTH-1:WIDTH]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            write_cycle(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, DEPTH - 1)),
                        WIDTH'($urandom));
            for (int k = 0; k < RD_PORTS; k++) begin
                if (k == 1 && $urandom_range(0, 3) == 0)
                    set_port(k, rd_sel[SEL_W-1:0], 1'($urandom_range(0, 1)));
                else
                    set_port(k, SEL_W'($urandom_range(0, DEPTH - 1)), ($urandom_range(0, 4) != 0));
            end
            if ($urandom_range(0, 2) == 0 && mv) set_port(0, msel, 1'b1);
            check_ports("random");
        end
    endtask

    task automatic test_reset_mid();
        set_port(0, SEL_W'(7), 1'b1);
        set_port(1, SEL_W'(7), 1'b1);
        write_cycle(1'b0, SEL_W'(7), 16'h1234);
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b1 || rd_data !== '0) begin
            fails++;
            $display("FAIL mid_reset_async: busy=%b rd_data=%h expected busy=1 rd_data=0", busy, rd_data);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_clear("mid_reset_clear");
        #1;
        tests++;
        if (rd_data[WIDTH-1:0] !== 16'h0000) begin
            fails++;
            $display("FAIL mid_reset_r7: got %h expected 0000", rd_data[WIDTH-1:0]);
        end
        for (int r = 1; r < DEPTH; r++) begin
            set_port(0, SEL_W'(r), 1'b1);
            check_ports("mid_reset_zero");
        end
    endtask

    initial begin
        rd_sel = '0;
        rd_en  = '0;
        model_reset();
        test_reset();
        test_basic();
        test_r0();
        test_back_to_back();
        test_ports();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
